// File: rtl/multi_cycle_controller_pkg.sv
// rtl/multi_cycle_controller_pkg.sv - shared state, opcode, immediate and ALU select codes
package multi_cycle_controller_pkg;

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_OP,
    CLS_OPIMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_LUI
  } instr_class_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;

  localparam logic [1:0] ITypeImm = 2'd0;
  localparam logic [1:0] STypeImm = 2'd1;
  localparam logic [1:0] BTypeImm = 2'd2;
  localparam logic [1:0] UTypeImm = 2'd3;

  localparam logic [1:0] ALU_A_PC   = 2'd0;
  localparam logic [1:0] ALU_A_RS1  = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;

  localparam logic [1:0] ALU_B_RS2  = 2'd0;
  localparam logic [1:0] ALU_B_IMM  = 2'd1;
  localparam logic [1:0] ALU_B_FOUR = 2'd2;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_SUB   = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

endpackage

// File: rtl/multi_cycle_controller_if.sv
// rtl/multi_cycle_controller_if.sv - controller <-> datapath/memory signal bundle
interface multi_cycle_controller_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       aluZero;
  logic       memReady;
  logic       memReq;
  logic       memWe;
  logic       iorD;
  logic       irWrite;
  logic       pcWrite;
  logic       pcSrc;
  logic       regWrite;
  logic       memToReg;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] immType;
  logic       illegalInstr;
  logic [2:0] state;

  modport master (
    input  opcode, funct3, aluZero, memReady,
    output memReq, memWe, iorD, irWrite, pcWrite, pcSrc, regWrite, memToReg,
    output aluSrcA, aluSrcB, aluOp, immType, illegalInstr, state
  );

  modport slave (
    output opcode, funct3, aluZero, memReady,
    input  memReq, memWe, iorD, irWrite, pcWrite, pcSrc, regWrite, memToReg,
    input  aluSrcA, aluSrcB, aluOp, immType, illegalInstr, state
  );

endinterface

// File: rtl/multi_cycle_controller_main_decoder.sv
// rtl/multi_cycle_controller_main_decoder.sv - combinational opcode/funct3 class decoder
module main_decoder
  import multi_cycle_controller_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  output instr_class_t instr_class,
  output logic [1:0]   imm_type,
  output logic         legal
);

  always_comb begin
    instr_class = CLS_NONE;
    imm_type    = ITypeImm;
    legal       = 1'b1;
    case (opcode)
      OPCODE_OP:    instr_class = CLS_OP;
      OPCODE_OPIMM: instr_class = CLS_OPIMM;
      OPCODE_LOAD:  instr_class = CLS_LOAD;
      OPCODE_STORE: begin
        instr_class = CLS_STORE;
        imm_type    = STypeImm;
      end
      OPCODE_BRANCH: begin
        // Only BEQ/BNE exist here; other branch flavours are rejected
        if (funct3[2:1] == 2'b00) begin
          instr_class = CLS_BRANCH;
          imm_type    = BTypeImm;
        end else begin
          legal = 1'b0;
        end
      end
      OPCODE_LUI: begin
        instr_class = CLS_LUI;
        imm_type    = UTypeImm;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - FETCH/DECODE/EXEC/MEM/WB control FSM for the multi-cycle core
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                       clk,
  input  logic                       rstN,
  multi_cycle_controller_if.master   bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("multi_cycle_controller: unsupported XLEN");
  end

  state_t       state_q;
  state_t       state_d;
  instr_class_t cls;
  logic [1:0]   dec_imm;
  logic         dec_legal;
  logic         branch_taken;

  main_decoder u_main_decoder (
    .opcode      (bus.opcode),
    .funct3      (bus.funct3),
    .instr_class (cls),
    .imm_type    (dec_imm),
    .legal       (dec_legal)
  );

  assign branch_taken = bus.funct3[0] ? !bus.aluZero : bus.aluZero;
  assign bus.state    = state_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= S_START;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    bus.memReq       = 1'b0;
    bus.memWe        = 1'b0;
    bus.iorD         = 1'b0;
    bus.irWrite      = 1'b0;
    bus.pcWrite      = 1'b0;
    bus.pcSrc        = 1'b0;
    bus.regWrite     = 1'b0;
    bus.memToReg     = 1'b0;
    bus.aluSrcA      = ALU_A_PC;
    bus.aluSrcB      = ALU_B_RS2;
    bus.aluOp        = ALU_OP_ADD;
    bus.immType      = ITypeImm;
    bus.illegalInstr = 1'b0;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        bus.memReq  = 1'b1;
        bus.aluSrcA = ALU_A_PC;
        bus.aluSrcB = ALU_B_FOUR;
        bus.aluOp   = ALU_OP_ADD;
        if (bus.memReady) begin
          bus.irWrite = 1'b1;
          bus.pcWrite = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.immType = dec_imm;
        if (!dec_legal) begin
          bus.illegalInstr = 1'b1;
          state_d          = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        bus.immType = dec_imm;
        state_d     = S_WB;
        case (cls)
          CLS_OP: begin
            bus.aluSrcA = ALU_A_RS1;
            bus.aluSrcB = ALU_B_RS2;
            bus.aluOp   = ALU_OP_FUNCT;
          end
          CLS_OPIMM: begin
            bus.aluSrcA = ALU_A_RS1;
            bus.aluSrcB = ALU_B_IMM;
            bus.aluOp   = ALU_OP_FUNCT;
          end
          CLS_LOAD, CLS_STORE: begin
            bus.aluSrcA = ALU_A_RS1;
            bus.aluSrcB = ALU_B_IMM;
            bus.aluOp   = ALU_OP_ADD;
            state_d     = S_MEM;
          end
          CLS_LUI: begin
            bus.aluSrcA = ALU_A_ZERO;
            bus.aluSrcB = ALU_B_IMM;
            bus.aluOp   = ALU_OP_ADD;
          end
          CLS_BRANCH: begin
            // rs1 - rs2 feeds aluZero; the target comes from the separate adder
            bus.aluSrcA = ALU_A_RS1;
            bus.aluSrcB = ALU_B_RS2;
            bus.aluOp   = ALU_OP_SUB;
            bus.pcSrc   = 1'b1;
            bus.pcWrite = branch_taken;
            state_d     = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        bus.immType = dec_imm;
        bus.memReq  = 1'b1;
        bus.iorD    = 1'b1;
        bus.memWe   = (cls == CLS_STORE);
        if (bus.memReady) begin
          state_d = (cls == CLS_STORE) ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        bus.immType  = dec_imm;
        bus.regWrite = 1'b1;
        bus.memToReg = (cls == CLS_LOAD);
        state_d      = S_FETCH;
      end
      default: state_d = S_START;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - table-driven bench for multi_cycle_controller
module tb_multi_cycle_controller;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       z;
    int         wait_n;
    int         cyc;
    int         imm;
    int         ill;
    int         ea;
    int         eb;
    int         eop;
    int         pcw;
    int         pcsrc;
    int         memc;
    int         mwe;
    int         rw;
    int         m2r;
  } vec_t;

  logic clk;
  logic rstN;
  int   n_cmp;
  int   n_bad;

  multi_cycle_controller_if bus ();

  multi_cycle_controller #(.XLEN(32)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int all_outputs();
    return int'({bus.memReq, bus.memWe, bus.iorD, bus.irWrite, bus.pcWrite, bus.pcSrc,
                 bus.regWrite, bus.memToReg, bus.aluSrcA, bus.aluSrcB, bus.aluOp,
                 bus.immType, bus.illegalInstr});
  endfunction

  task automatic run_instr(input int idx, input vec_t v);
    int cyc, memc, ill, rw, imm, ea, eb, eop, pcw, pcsrc, mwe, m2r, bad, fetch_ok;
    cyc = 0; memc = 0; ill = 0; rw = 0; bad = 0; fetch_ok = 0;
    imm = -1; ea = -1; eb = -1; eop = -1; pcw = -1; pcsrc = -1; mwe = -1; m2r = -1;
    bus.opcode  = v.opc;
    bus.funct3  = v.f3;
    bus.aluZero = v.z;
    do begin
      case (bus.state)
        3'd1:    bus.memReady = 1'b1;
        3'd4:    bus.memReady = (memc >= v.wait_n);
        default: bus.memReady = 1'($urandom_range(0, 1));
      endcase
      #1;
      case (bus.state)
        3'd1: fetch_ok = int'(bus.memReq && !bus.memWe && !bus.iorD && bus.irWrite &&
                              bus.pcWrite && !bus.pcSrc && bus.aluSrcA == 2'd0 &&
                              bus.aluSrcB == 2'd2 && bus.aluOp == 2'd0);
        3'd2: imm = int'(bus.immType);
        3'd3: begin
          ea = int'(bus.aluSrcA); eb = int'(bus.aluSrcB); eop = int'(bus.aluOp);
          pcw = int'(bus.pcWrite); pcsrc = int'(bus.pcSrc);
        end
        3'd4: begin
          memc++;
          if (bus.memReq && bus.iorD) mwe = int'(bus.memWe);
          else bad++;
        end
        3'd5: m2r = int'(bus.memToReg);
        default: bad++;
      endcase
      ill += int'(bus.illegalInstr);
      rw  += int'(bus.regWrite);
      if (bus.regWrite && bus.memWe) bad++;
      if (bus.irWrite && bus.state != 3'd1) bad++;
      if (bus.pcWrite && bus.state != 3'd1 && bus.state != 3'd3) bad++;
      if (bus.memReq && bus.state != 3'd1 && bus.state != 3'd4) bad++;
      if (bus.regWrite && bus.state != 3'd5) bad++;
      if (bus.illegalInstr && bus.state != 3'd2) bad++;
      @(posedge clk);
      #1;
      cyc++;
    end while (bus.state != 3'd1 && cyc < 30);
    chk($sformatf("v%0d cycles", idx), cyc, v.cyc);
    chk($sformatf("v%0d fetch_outputs", idx), fetch_ok, 1);
    chk($sformatf("v%0d decode_immType", idx), imm, v.imm);
    chk($sformatf("v%0d illegal_pulses", idx), ill, v.ill);
    chk($sformatf("v%0d exec_aluSrcA", idx), ea, v.ea);
    chk($sformatf("v%0d exec_aluSrcB", idx), eb, v.eb);
    chk($sformatf("v%0d exec_aluOp", idx), eop, v.eop);
    chk($sformatf("v%0d exec_pcWrite", idx), pcw, v.pcw);
    chk($sformatf("v%0d exec_pcSrc", idx), pcsrc, v.pcsrc);
    chk($sformatf("v%0d mem_cycles", idx), memc, v.memc);
    chk($sformatf("v%0d mem_memWe", idx), mwe, v.mwe);
    chk($sformatf("v%0d regWrite_count", idx), rw, v.rw);
    chk($sformatf("v%0d wb_memToReg", idx), m2r, v.m2r);
    chk($sformatf("v%0d rule_violations", idx), bad, 0);
  endtask

  vec_t vecs[14];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //             opc         f3      z     w  cyc imm ill ea  eb  eop pcw pcs memc mwe rw m2r
    vecs[0]  = '{7'b0010011, 3'b000, 1'b0, 0, 4, 0, 0, 1, 1, 2, 0, 0, 0, -1, 1, 0};
    vecs[1]  = '{7'b0110011, 3'b000, 1'b1, 0, 4, 0, 0, 1, 0, 2, 0, 0, 0, -1, 1, 0};
    vecs[2]  = '{7'b0110111, 3'b000, 1'b0, 0, 4, 3, 0, 2, 1, 0, 0, 0, 0, -1, 1, 0};
    vecs[3]  = '{7'b0000011, 3'b010, 1'b0, 0, 5, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1};
    vecs[4]  = '{7'b0000011, 3'b010, 1'b0, 3, 8, 0, 0, 1, 1, 0, 0, 0, 4, 0, 1, 1};
    vecs[5]  = '{7'b0100011, 3'b010, 1'b0, 0, 4, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0, -1};
    vecs[6]  = '{7'b0100011, 3'b010, 1'b1, 2, 6, 1, 0, 1, 1, 0, 0, 0, 3, 1, 0, -1};
    vecs[7]  = '{7'b1100011, 3'b000, 1'b1, 0, 3, 2, 0, 1, 0, 1, 1, 1, 0, -1, 0, -1};
    vecs[8]  = '{7'b1100011, 3'b000, 1'b0, 0, 3, 2, 0, 1, 0, 1, 0, 1, 0, -1, 0, -1};
    vecs[9]  = '{7'b1100011, 3'b001, 1'b1, 0, 3, 2, 0, 1, 0, 1, 0, 1, 0, -1, 0, -1};
    vecs[10] = '{7'b1100011, 3'b001, 1'b0, 0, 3, 2, 0, 1, 0, 1, 1, 1, 0, -1, 0, -1};
    vecs[11] = '{7'b1111111, 3'b000, 1'b0, 0, 2, 0, 1, -1, -1, -1, -1, -1, 0, -1, 0, -1};
    vecs[12] = '{7'b1100011, 3'b010, 1'b1, 0, 2, 0, 1, -1, -1, -1, -1, -1, 0, -1, 0, -1};
    vecs[13] = '{7'b0000000, 3'b000, 1'b0, 0, 2, 0, 1, -1, -1, -1, -1, -1, 0, -1, 0, -1};

    rstN         = 1'b0;
    bus.opcode   = 7'b0010011;
    bus.funct3   = 3'b000;
    bus.aluZero  = 1'b0;
    bus.memReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", int'(bus.state), 0);
    chk("reset outputs", all_outputs(), 0);

    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    chk("release state", int'(bus.state), 1);
    chk("release memReq", int'(bus.memReq), 1);

    // Instruction fetch stalls: outputs hold, no IR/PC load
    bus.memReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("fetch_wait%0d state", i), int'(bus.state), 1);
      chk($sformatf("fetch_wait%0d memReq", i), int'(bus.memReq), 1);
      chk($sformatf("fetch_wait%0d irWrite", i), int'(bus.irWrite), 0);
      chk($sformatf("fetch_wait%0d pcWrite", i), int'(bus.pcWrite), 0);
      chk($sformatf("fetch_wait%0d aluSrcB", i), int'(bus.aluSrcB), 2);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 14; i++) run_instr(i, vecs[i]);

    // Reset while a fetch is outstanding
    bus.memReady = 1'b0;
    #1;
    chk("midfetch memReq before reset", int'(bus.memReq), 1);
    rstN = 1'b0;
    #1;
    chk("midfetch reset memReq", int'(bus.memReq), 0);
    chk("midfetch reset state", int'(bus.state), 0);
    chk("midfetch reset outputs", all_outputs(), 0);
    bus.memReady = 1'b1;
    @(posedge clk);
    #1;
    chk("held reset state", int'(bus.state), 0);
    chk("held reset outputs", all_outputs(), 0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    chk("start state after release", int'(bus.state), 0);
    @(posedge clk);
    #1;
    chk("refetch state", int'(bus.state), 1);
    chk("refetch memReq", int'(bus.memReq), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
